uart_tx_mode_ctrl: RTL and testbench

//  Byte-driven command decoder for the UART TX path: consumes received ASCII bytes one per valid

---
 rtl/uart_tx_mode_ctrl_if.sv | 10 +
 rtl/uart_tx_mode_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_tx_mode_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mode_ctrl_if.sv
// Received-byte bus feeding the TX mode decoder.
// One byte per cycle in which idata_valid is high.
// No backpressure: the consumer accepts every strobed byte.
interface uart_tx_mode_ctrl_if;
  logic [7:0] idata;
  logic       idata_valid;

  modport master (output idata, output idata_valid);
  modport slave  (input  idata, input  idata_valid);
endinterface

// File: rtl/uart_tx_mode_ctrl.sv
// UART TX mode/rate command decoder: IDLE / NORMAL / CONTROL selected by strobed ASCII bytes.
// Latency: one cycle; every output reflects the byte sampled at the previous edge.
// No backpressure: each valid byte is consumed in the cycle it is presented.
module uart_tx_mode_ctrl #(
  parameter logic [7:0] RATE_DEFAULT = 8'h31,
  parameter logic [7:0] RATE_CODE0   = 8'h31,
  parameter logic [7:0] RATE_CODE1   = 8'h35,
  parameter logic [7:0] RATE_CODE2   = 8'h41,
  parameter int         TIMEOUT_CYC  = 1000000,
  parameter int         TMO_W        = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_tx_mode_ctrl_if.slave         rx,
  input  logic                       iSTART,
  output logic                       oTX_INITIAL,
  output logic                       oTX_NORMAL,
  output logic                       oTX_START_CONTROL,
  output logic [7:0]                 oTX_rate,
  output logic                       oRATE_UPDATE,
  output logic                       oCMD_ERR,
  output logic                       oTIMEOUT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NORMAL  = 2'd1,
    ST_CONTROL = 2'd2
  } state_t;

  // Last counter value before abort; unused when the timeout is disabled.
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TMO_W'(TIMEOUT_CYC - 1) : '0;
  localparam bit               TMO_EN   = (TIMEOUT_CYC > 0);

  state_t           state, state_n;
  logic [7:0]       pending, pending_n;
  logic [7:0]       rate_n;
  logic [TMO_W-1:0] cnt, cnt_n;
  logic             upd_n, err_n, tmo_n;

  logic is_m, is_c, is_f, is_rate;

  // Byte classification, qualified by the strobe so held data is never decoded.
  always_comb begin
    is_m    = rx.idata_valid && (rx.idata == 8'h4D || rx.idata == 8'h6D);
    is_c    = rx.idata_valid && (rx.idata == 8'h43 || rx.idata == 8'h63);
    is_f    = rx.idata_valid && (rx.idata == 8'h46 || rx.idata == 8'h66);
    is_rate = rx.idata_valid && (rx.idata == RATE_CODE0 || rx.idata == RATE_CODE1 ||
                                 rx.idata == RATE_CODE2);
  end

  // Next-state, staged rate, timeout counter and pulse decode.
  always_comb begin
    state_n   = state;
    pending_n = pending;
    rate_n    = oTX_rate;
    cnt_n     = cnt;
    upd_n     = 1'b0;
    err_n     = 1'b0;
    tmo_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_m) begin
          state_n   = ST_CONTROL;
          pending_n = oTX_rate;
          cnt_n     = '0;
        end else if (iSTART) begin
          state_n = ST_NORMAL;
        end
      end
      ST_NORMAL: begin
        if (is_m) begin
          state_n   = ST_CONTROL;
          pending_n = oTX_rate;
          cnt_n     = '0;
        end else if (is_c) begin
          state_n = ST_IDLE;
          rate_n  = RATE_DEFAULT;
        end
      end
      ST_CONTROL: begin
        if (rx.idata_valid) begin
          cnt_n = '0;
          if (is_rate) begin
            pending_n = rx.idata;
          end else if (is_f) begin
            state_n = ST_NORMAL;
            rate_n  = pending;
            upd_n   = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else if (TMO_EN) begin
          if (cnt == TMO_LAST) begin
            // Abort: the staged rate is dropped and the default restored.
            state_n = ST_IDLE;
            rate_n  = RATE_DEFAULT;
            tmo_n   = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers; mode outputs are flopped from the next state so they stay one-hot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      pending           <= RATE_DEFAULT;
      cnt               <= '0;
      oTX_rate          <= RATE_DEFAULT;
      oTX_INITIAL       <= 1'b1;
      oTX_NORMAL        <= 1'b0;
      oTX_START_CONTROL <= 1'b0;
      oRATE_UPDATE      <= 1'b0;
      oCMD_ERR          <= 1'b0;
      oTIMEOUT          <= 1'b0;
    end else begin
      state             <= state_n;
      pending           <= pending_n;
      cnt               <= cnt_n;
      oTX_rate          <= rate_n;
      oTX_INITIAL       <= (state_n == ST_IDLE);
      oTX_NORMAL        <= (state_n == ST_NORMAL);
      oTX_START_CONTROL <= (state_n == ST_CONTROL);
      oRATE_UPDATE      <= upd_n;
      oCMD_ERR          <= err_n;
      oTIMEOUT          <= tmo_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_mode_ctrl.sv
// Self-checking bench for uart_tx_mode_ctrl: directed vector table, timeout sequences,
// then randomized traffic against a behavioural model.
module tb_uart_tx_mode_ctrl;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       o_init, o_norm, o_ctrl, o_upd, o_err, o_tmo;
  logic [7:0] o_rate;

  uart_tx_mode_ctrl_if bus ();

  uart_tx_mode_ctrl #(.TIMEOUT_CYC(TMO), .TMO_W(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .rx                (bus.slave),
    .iSTART            (start),
    .oTX_INITIAL       (o_init),
    .oTX_NORMAL        (o_norm),
    .oTX_START_CONTROL (o_ctrl),
    .oTX_rate          (o_rate),
    .oRATE_UPDATE      (o_upd),
    .oCMD_ERR          (o_err),
    .oTIMEOUT          (o_tmo)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  localparam logic [2:0] MI = 3'b100, MN = 3'b010, MC = 3'b001;

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       s;
    logic [2:0] mode;
    logic [7:0] rate;
    logic [2:0] pl;   // {rate_update, cmd_err, timeout}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v, logic [7:0] d, logic s,
                              logic [2:0] mode, logic [7:0] rate, logic [2:0] pl);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.s = s; r.mode = mode; r.rate = rate; r.pl = pl;
    return r;
  endfunction

  function automatic logic [13:0] obs();
    return {o_init, o_norm, o_ctrl, o_rate, o_upd, o_err, o_tmo};
  endfunction

  task automatic check(string name, logic [13:0] exp);
    logic [13:0] got;
    got = obs();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got mode=%b rate=%h upd/err/tmo=%b, expected mode=%b rate=%h upd/err/tmo=%b",
               name, got[13:11], got[10:3], got[2:0], exp[13:11], exp[10:3], exp[2:0]);
    end
  endtask

  // Present one cycle of inputs, then settle just past the edge for sampling.
  task automatic drive(logic rst, logic v, logic [7:0] d, logic s);
    reset           = rst;
    bus.idata_valid = v;
    bus.idata       = d;
    start           = s;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_mode;    // 0 idle, 1 normal, 2 control
  logic [7:0] m_rate, m_pend;
  int         m_quiet;   // consecutive strobe-free cycles spent in control
  logic       m_upd, m_err, m_tmo;

  task automatic model_step(logic rst, logic v, logic [7:0] d, logic s);
    logic [7:0] up;
    up = d & 8'hDF;   // ASCII upper-case fold
    m_upd = 0; m_err = 0; m_tmo = 0;
    if (rst) begin
      m_mode = 0; m_rate = 8'h31; m_pend = 8'h31; m_quiet = 0;
    end else if (m_mode == 0 || m_mode == 1) begin
      if (v && up == "M") begin
        m_mode = 2; m_pend = m_rate; m_quiet = 0;
      end else if (m_mode == 0 && s) begin
        m_mode = 1;
      end else if (m_mode == 1 && v && up == "C") begin
        m_mode = 0; m_rate = 8'h31;
      end
    end else begin
      if (v) begin
        m_quiet = 0;
        if (d inside {8'h31, 8'h35, 8'h41}) m_pend = d;
        else if (up == "F") begin m_mode = 1; m_rate = m_pend; m_upd = 1; end
        else m_err = 1;
      end else begin
        m_quiet++;
        if (m_quiet == TMO) begin
          m_mode = 0; m_rate = 8'h31; m_tmo = 1;
        end
      end
    end
  endtask

  function automatic logic [13:0] model_exp();
    logic [2:0] oh;
    oh = (m_mode == 0) ? MI : (m_mode == 1) ? MN : MC;
    return {oh, m_rate, m_upd, m_err, m_tmo};
  endfunction

  logic [7:0] pool [12] = '{8'h4D, 8'h6D, 8'h43, 8'h63, 8'h46, 8'h66,
                            8'h31, 8'h35, 8'h41, 8'h61, 8'h58, 8'h00};

  initial begin
    reset = 1'b1; start = 1'b0; bus.idata = 8'h00; bus.idata_valid = 1'b0;

    // Directed table: each row is one clock of inputs and the outputs expected after it.
    tbl.push_back(mk(1, 0, 8'h00, 0, MI, 8'h31, 3'b000));
    tbl.push_back(mk(1, 0, 8'h00, 0, MI, 8'h31, 3'b000));
    tbl.push_back(mk(0, 0, 8'h00, 0, MI, 8'h31, 3'b000));
    tbl.push_back(mk(0, 0, 8'h00, 1, MN, 8'h31, 3'b000));  // iSTART -> NORMAL
    tbl.push_back(mk(0, 1, "m",   0, MC, 8'h31, 3'b000));
    tbl.push_back(mk(0, 1, "5",   0, MC, 8'h31, 3'b000));  // staged only
    tbl.push_back(mk(0, 1, "F",   0, MN, 8'h35, 3'b100));
    tbl.push_back(mk(0, 0, 8'h00, 0, MN, 8'h35, 3'b000));  // pulse is one cycle
    tbl.push_back(mk(0, 1, "M",   0, MC, 8'h35, 3'b000));
    tbl.push_back(mk(0, 1, "A",   0, MC, 8'h35, 3'b000));
    tbl.push_back(mk(0, 1, "X",   0, MC, 8'h35, 3'b010));
    tbl.push_back(mk(0, 1, "f",   0, MN, 8'h41, 3'b100));
    tbl.push_back(mk(0, 0, "c",   0, MN, 8'h41, 3'b000));  // unstrobed byte ignored
    tbl.push_back(mk(0, 0, "M",   1, MN, 8'h41, 3'b000));  // iSTART ignored in NORMAL
    tbl.push_back(mk(0, 1, "c",   0, MI, 8'h31, 3'b000));
    tbl.push_back(mk(0, 0, "M",   0, MI, 8'h31, 3'b000));
    tbl.push_back(mk(0, 1, "X",   0, MI, 8'h31, 3'b000));  // no error in IDLE
    tbl.push_back(mk(0, 1, "M",   1, MC, 8'h31, 3'b000));  // 'M' beats iSTART
    tbl.push_back(mk(0, 1, "a",   0, MC, 8'h31, 3'b010));  // lowercase rate is an error
    tbl.push_back(mk(0, 1, "5",   0, MC, 8'h31, 3'b000));
    tbl.push_back(mk(1, 0, 8'h00, 0, MI, 8'h31, 3'b000));  // reset mid-CONTROL
    tbl.push_back(mk(0, 1, "M",   0, MC, 8'h31, 3'b000));
    tbl.push_back(mk(0, 1, "M",   0, MC, 8'h31, 3'b010));  // 'M' in CONTROL is an error
    tbl.push_back(mk(0, 1, "C",   0, MC, 8'h31, 3'b010));  // so is 'C'
    tbl.push_back(mk(0, 1, "F",   0, MN, 8'h31, 3'b100));  // update even when unchanged
    tbl.push_back(mk(0, 1, "C",   0, MI, 8'h31, 3'b000));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].s);
      check($sformatf("table[%0d]", i), {tbl[i].mode, tbl[i].rate, tbl[i].pl});
    end

    // Timeout abort from CONTROL with a non-default committed rate.
    drive(0, 0, 8'h00, 1); check("to_start", {MN, 8'h31, 3'b000});
    drive(0, 1, "M", 0);   check("to_m1",    {MC, 8'h31, 3'b000});
    drive(0, 1, "5", 0);   check("to_5",     {MC, 8'h31, 3'b000});
    drive(0, 1, "F", 0);   check("to_f",     {MN, 8'h35, 3'b100});
    drive(0, 1, "M", 0);   check("to_m2",    {MC, 8'h35, 3'b000});
    for (int i = 1; i < TMO; i++) begin
      drive(0, 0, 8'h00, 0); check($sformatf("to_wait%0d", i), {MC, 8'h35, 3'b000});
    end
    drive(0, 0, 8'h00, 0); check("to_fire", {MI, 8'h31, 3'b001});
    drive(0, 0, 8'h00, 0); check("to_after", {MI, 8'h31, 3'b000});

    // A strobe on the would-be timeout cycle wins and restarts the count.
    drive(0, 1, "M", 0);   check("tr_m", {MC, 8'h31, 3'b000});
    for (int i = 1; i < TMO; i++) begin
      drive(0, 0, 8'h00, 0); check($sformatf("tr_wait%0d", i), {MC, 8'h31, 3'b000});
    end
    drive(0, 1, "5", 0);   check("tr_strobe", {MC, 8'h31, 3'b000});
    for (int i = 1; i < TMO; i++) begin
      drive(0, 0, 8'h00, 0); check($sformatf("tr_rewait%0d", i), {MC, 8'h31, 3'b000});
    end
    drive(0, 0, 8'h00, 0); check("tr_fire", {MI, 8'h31, 3'b001});

    // Randomized traffic against the model.
    model_step(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    check("rnd_reset", model_exp());
    for (int i = 0; i < 4000; i++) begin
      logic       r, v, s;
      logic [7:0] d;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      model_step(r, v, d, s);
      drive(r, v, d, s);
      check($sformatf("rnd[%0d]", i), model_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
